// File: rtl/sort4_result_checker.sv
// Checks each (input, sorted output) pair from the 4-lane sorter and keeps pass/fail counts.
// Define SORT4_CHECK_PERM_EN to also require the output to be a permutation of the input.
module sort4_result_checker #(
    parameter int DW = 3,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*DW-1:0] inp,
    input  logic [4*DW-1:0] outp,
    output logic            check_done,
    output logic            check_pass,
    output logic [CW-1:0]   sample_count,
    output logic [CW-1:0]   err_count,
    output logic [4*DW-1:0] first_err_inp,
    output logic            err_seen
);
    typedef enum logic [1:0] {IDLE, ORDER, PERM, REPORT} state_t;

    state_t          state;
    logic [4*DW-1:0] cap_inp;
    logic [4*DW-1:0] cap_outp;
    logic            ord_now;
    logic            fin;
    logic            verdict;

    function automatic logic [DW-1:0] lane(input logic [4*DW-1:0] w, input int k);
        return w[k*DW +: DW];
    endfunction

    assign in_ready = rst_n && (state == IDLE);
    assign ord_now  = (lane(cap_outp, 0) <= lane(cap_outp, 1)) &&
                      (lane(cap_outp, 1) <= lane(cap_outp, 2)) &&
                      (lane(cap_outp, 2) <= lane(cap_outp, 3));

`ifdef SORT4_CHECK_PERM_EN
    logic [1:0] idx;
    logic [3:0] used;
    logic [3:0] pick;
    logic       ord_ok;
    logic       perm_ok;
    logic       hit;

    // Lowest-index outp lane not yet claimed that matches the current inp lane.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int j = 0; j < 4; j++) begin
            if (!hit && !used[j] && (lane(cap_outp, j) == lane(cap_inp, int'(idx)))) begin
                hit     = 1'b1;
                pick[j] = 1'b1;
            end
        end
    end

    assign fin     = (state == PERM) && (idx == 2'd3);
    assign verdict = ord_ok && perm_ok && hit;
`else
    assign fin     = (state == ORDER);
    assign verdict = ord_now;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cap_inp       <= '0;
            cap_outp      <= '0;
            check_done    <= 1'b0;
            check_pass    <= 1'b0;
            sample_count  <= '0;
            err_count     <= '0;
            first_err_inp <= '0;
            err_seen      <= 1'b0;
`ifdef SORT4_CHECK_PERM_EN
            idx           <= '0;
            used          <= '0;
            ord_ok        <= 1'b0;
            perm_ok       <= 1'b0;
`endif
        end else begin
            check_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_inp  <= inp;
                        cap_outp <= outp;
                        state    <= ORDER;
                    end
                end
                ORDER: begin
`ifdef SORT4_CHECK_PERM_EN
                    ord_ok  <= ord_now;
                    perm_ok <= 1'b1;
                    used    <= '0;
                    idx     <= '0;
                    state   <= PERM;
`endif
                end
`ifdef SORT4_CHECK_PERM_EN
                PERM: begin
                    used <= used | pick;
                    if (!hit) perm_ok <= 1'b0;
                    idx  <= idx + 2'd1;
                end
`endif
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Verdict and counters land together on the edge that enters REPORT.
            if (fin) begin
                state        <= REPORT;
                check_done   <= 1'b1;
                check_pass   <= verdict;
                sample_count <= sample_count + CW'(1);
                if (!verdict) begin
                    if (err_count != '1) err_count <= err_count + CW'(1);
                    err_seen <= 1'b1;
                    if (!err_seen) first_err_inp <= cap_inp;
                end
            end
        end
    end
endmodule
